// File: rtl/sample_scheduler_pkg.sv
// Shared widths, FSM encoding and helpers for the sample_scheduler block.
package sample_scheduler_pkg;

  localparam int RAW_WIDTH       = 8;
  localparam int INPUT_CHANNELS  = 4;
  localparam int MODE_WIDTH      = 2;
  localparam int LABEL_WIDTH     = 4;
  localparam int RAW_BUS_WIDTH   = RAW_WIDTH * INPUT_CHANNELS;
  localparam int SCHED_OVF_WIDTH = 16;

  typedef enum logic {
    SCHED_IDLE = 1'b0,
    SCHED_HOLD = 1'b1
  } sched_state_e;

  typedef struct packed {
    logic [RAW_BUS_WIDTH-1:0] raw;
    logic [MODE_WIDTH-1:0]    mode;
    logic [LABEL_WIDTH-1:0]   label;
  } sample_t;

  function automatic int ceil_log2(input int value);
    int bits;
    bits = 0;
    while ((1 << bits) < value) bits++;
    return bits;
  endfunction

endpackage

// File: rtl/sample_tick_gen.sv
// Sample-rate strobe: one tick every CLK_PER_SAMPLE enabled cycles, cleared while disabled.
module sample_tick_gen
  import sample_scheduler_pkg::*;
#(
  parameter int CLK_PER_SAMPLE = 10
) (
  input  logic Clk_CI,
  input  logic Reset_RI,
  input  logic Enable_SI,
  output logic Tick_SO
);

  localparam int CNT_W = ceil_log2(CLK_PER_SAMPLE);
  localparam logic [CNT_W-1:0] TERMINAL = CNT_W'(CLK_PER_SAMPLE - 1);

  logic [CNT_W-1:0] count;

  // NOTE: non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge Clk_CI or posedge Reset_RI) begin
    if (Reset_RI) begin
      count <= '0;
    end else if (!Enable_SI || count == TERMINAL) begin
      count <= '0;
    end else begin
      count <= count + CNT_W'(1);
    end
  end

  assign Tick_SO = Enable_SI && (count == TERMINAL);

endmodule

// File: rtl/sample_scheduler.sv
// Captures one sample per tick and offers it to the encoder over valid/ready, counting overruns.
// Optional SAMPLE_SCHED_SKID_EN adds a one-entry skid register in front of the overrun path.
module sample_scheduler
  import sample_scheduler_pkg::*;
#(
  parameter int CLK_PER_SAMPLE = 10,
  parameter int OVF_WIDTH      = SCHED_OVF_WIDTH
) (
  input  logic                     Clk_CI,
  input  logic                     Reset_RI,
  input  logic                     Enable_SI,
  input  logic [RAW_BUS_WIDTH-1:0] Raw_DI,
  input  logic [MODE_WIDTH-1:0]    ModeIn_SI,
  input  logic [LABEL_WIDTH-1:0]   LabelIn_DI,
  input  logic                     ReadyIn_SI,
  output logic                     ValidOut_SO,
  output logic [RAW_BUS_WIDTH-1:0] Raw_DO,
  output logic [MODE_WIDTH-1:0]    ModeOut_SO,
  output logic [LABEL_WIDTH-1:0]   LabelOut_DO,
  output logic                     Tick_SO,
  output logic [OVF_WIDTH-1:0]     OverrunCnt_DO
);

  logic                 tick;
  sched_state_e         state, state_next;
  sample_t              live, held, held_next;
  logic                 overrun;
  logic [OVF_WIDTH-1:0] ovf_cnt;
`ifdef SAMPLE_SCHED_SKID_EN
  sample_t              skid, skid_next;
  logic                 skid_full, skid_full_next;
`endif

  sample_tick_gen #(
    .CLK_PER_SAMPLE(CLK_PER_SAMPLE)
  ) u_tick_gen (
    .Clk_CI   (Clk_CI),
    .Reset_RI (Reset_RI),
    .Enable_SI(Enable_SI),
    .Tick_SO  (tick)
  );

  assign live = {Raw_DI, ModeIn_SI, LabelIn_DI};

  // NOTE: every always_comb output gets a default first so no path infers a latch.
  always_comb begin
    state_next = state;
    held_next  = held;
    overrun    = 1'b0;
`ifdef SAMPLE_SCHED_SKID_EN
    skid_next      = skid;
    skid_full_next = skid_full;
`endif
    unique case (state)
      SCHED_IDLE: begin
        if (tick) begin
          held_next  = live;
          state_next = SCHED_HOLD;
        end
      end
      SCHED_HOLD: begin
        // ValidOut_SO is high throughout HOLD, so ReadyIn_SI alone marks the handshake.
`ifdef SAMPLE_SCHED_SKID_EN
        if (ReadyIn_SI) begin
          if (skid_full) begin
            held_next = skid;
            if (tick) skid_next = live;
            else      skid_full_next = 1'b0;
          end else if (tick) begin
            held_next = live;
          end else begin
            state_next = SCHED_IDLE;
          end
        end else if (tick) begin
          if (skid_full) begin
            overrun = 1'b1;
          end else begin
            skid_next      = live;
            skid_full_next = 1'b1;
          end
        end
`else
        if (ReadyIn_SI) begin
          if (tick) held_next  = live;
          else      state_next = SCHED_IDLE;
        end else if (tick) begin
          overrun = 1'b1;
        end
`endif
      end
    endcase
  end

  always_ff @(posedge Clk_CI or posedge Reset_RI) begin
    if (Reset_RI) begin
      state   <= SCHED_IDLE;
      held    <= '0;
      ovf_cnt <= '0;
`ifdef SAMPLE_SCHED_SKID_EN
      skid      <= '0;
      skid_full <= 1'b0;
`endif
    end else begin
      state <= state_next;
      held  <= held_next;
      if (overrun && ovf_cnt != '1) begin
        ovf_cnt <= ovf_cnt + OVF_WIDTH'(1);
      end
`ifdef SAMPLE_SCHED_SKID_EN
      skid      <= skid_next;
      skid_full <= skid_full_next;
`endif
    end
  end

  assign ValidOut_SO   = (state == SCHED_HOLD);
  assign Raw_DO        = held.raw;
  assign ModeOut_SO    = held.mode;
  assign LabelOut_DO   = held.label;
  assign Tick_SO       = tick;
  assign OverrunCnt_DO = ovf_cnt;

endmodule

// File: tb/tb_sample_scheduler.sv
// Randomized bench for sample_scheduler against a queue-based reference model.
module tb_sample_scheduler;
  import sample_scheduler_pkg::*;

  localparam int N        = 10;
  localparam int OW       = 2;
  localparam int OVF_MAX  = (1 << OW) - 1;
`ifdef SAMPLE_SCHED_SKID_EN
  localparam int CAP      = 2;
`else
  localparam int CAP      = 1;
`endif

  logic                     clk;
  logic                     rst;
  logic                     enable;
  logic [RAW_BUS_WIDTH-1:0] raw_in;
  logic [MODE_WIDTH-1:0]    mode_in;
  logic [LABEL_WIDTH-1:0]   label_in;
  logic                     ready;
  logic                     valid;
  logic [RAW_BUS_WIDTH-1:0] raw_out;
  logic [MODE_WIDTH-1:0]    mode_out;
  logic [LABEL_WIDTH-1:0]   label_out;
  logic                     tick;
  logic [OW-1:0]            ovf;

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model: samples waiting for the encoder, oldest first.
  sample_t q[$];
  int      ovf_m;
  int      en_run;

  sample_scheduler #(
    .CLK_PER_SAMPLE(N),
    .OVF_WIDTH     (OW)
  ) dut (
    .Clk_CI       (clk),
    .Reset_RI     (rst),
    .Enable_SI    (enable),
    .Raw_DI       (raw_in),
    .ModeIn_SI    (mode_in),
    .LabelIn_DI   (label_in),
    .ReadyIn_SI   (ready),
    .ValidOut_SO  (valid),
    .Raw_DO       (raw_out),
    .ModeOut_SO   (mode_out),
    .LabelOut_DO  (label_out),
    .Tick_SO      (tick),
    .OverrunCnt_DO(ovf)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    q.delete();
    ovf_m  = 0;
    en_run = 0;
  endtask

  task automatic check_zero(input string pfx);
    check({pfx, "_valid"}, valid, 0);
    check({pfx, "_raw"}, raw_out, 0);
    check({pfx, "_mode"}, mode_out, 0);
    check({pfx, "_label"}, label_out, 0);
    check({pfx, "_ovf"}, ovf, 0);
    check({pfx, "_tick"}, tick, 0);
  endtask

  task automatic apply_reset();
    @(negedge clk);
    rst    = 1'b1;
    enable = 1'b0;
    ready  = 1'b0;
    #1;
    check_zero("reset");
    model_reset();
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
  endtask

  // One clock cycle: drive inputs, compare outputs to the model, then advance the model.
  task automatic run_cycle(input logic en, input logic rdy, input logic [LABEL_WIDTH-1:0] lbl);
    logic    m_tick;
    logic    m_hs;
    sample_t s;
    @(negedge clk);
    enable   = en;
    ready    = rdy;
    label_in = lbl;
    raw_in   = RAW_BUS_WIDTH'($urandom);
    mode_in  = MODE_WIDTH'($urandom);
    #1;
    m_tick = en && ((en_run % N) == N - 1);
    check("tick", tick, m_tick);
    check("valid", valid, q.size() != 0);
    if (q.size() != 0) begin
      check("raw", raw_out, q[0].raw);
      check("mode", mode_out, q[0].mode);
      check("label", label_out, q[0].label);
    end
    check("overrun_cnt", ovf, ovf_m);
    m_hs = (q.size() != 0) && rdy;
    if (m_hs) void'(q.pop_front());
    if (m_tick) begin
      if (q.size() < CAP) begin
        s.raw   = raw_in;
        s.mode  = mode_in;
        s.label = label_in;
        q.push_back(s);
      end else if (ovf_m < OVF_MAX) begin
        ovf_m++;
      end
    end
    en_run = en ? en_run + 1 : 0;
  endtask

  task automatic measure_first_valid(input string tag);
    int first;
    first = -1;
    for (int c = 1; c <= N + 5; c++) begin
      run_cycle(1'b1, 1'b1, LABEL_WIDTH'($urandom));
      if (first < 0 && valid === 1'b1) first = c;
    end
    check(tag, first, N + 1);
  endtask

  initial begin
    logic [RAW_BUS_WIDTH-1:0] saved_raw;
    int valid_run;

    rst      = 1'b1;
    enable   = 1'b0;
    ready    = 1'b0;
    raw_in   = '0;
    mode_in  = '0;
    label_in = '0;
    model_reset();

    // Basic sequencing with ready always high.
    apply_reset();
    measure_first_valid("first_valid_cycle");
    for (int c = 0; c < 40; c++) run_cycle(1'b1, 1'b1, LABEL_WIDTH'($urandom));
    check("basic_ovf", ovf, 0);

    // Backpressure: ready low for 25 cycles after the first valid.
    apply_reset();
    for (int c = 1; c <= 10; c++) run_cycle(1'b1, 1'b1, LABEL_WIDTH'($urandom));
    run_cycle(1'b1, 1'b0, LABEL_WIDTH'($urandom));
    saved_raw = raw_out;
    for (int c = 12; c <= 35; c++) run_cycle(1'b1, 1'b0, LABEL_WIDTH'($urandom));
    check("bp_raw_stable", raw_out, saved_raw);
    run_cycle(1'b1, 1'b1, LABEL_WIDTH'($urandom));
    check("bp_ovf", ovf, (CAP == 2) ? 1 : 2);
    run_cycle(1'b1, 1'b1, LABEL_WIDTH'($urandom));
    check("bp_after_hs_valid", valid, (CAP == 2) ? 1 : 0);

    // Ready rises exactly in a tick cycle.
    apply_reset();
    for (int c = 1; c <= 10; c++) run_cycle(1'b1, 1'b1, LABEL_WIDTH'($urandom));
    for (int c = 11; c <= 19; c++) run_cycle(1'b1, 1'b0, LABEL_WIDTH'($urandom));
    run_cycle(1'b1, 1'b1, LABEL_WIDTH'($urandom));
    saved_raw = raw_in;
    run_cycle(1'b1, 1'b0, LABEL_WIDTH'($urandom));
    check("same_cycle_valid", valid, 1);
    check("same_cycle_raw", raw_out, saved_raw);
    check("same_cycle_ovf", ovf, 0);

    // Label is only sampled on the capturing tick.
    apply_reset();
    for (int c = 1; c <= 10; c++) run_cycle(1'b1, 1'b1, LABEL_WIDTH'(2));
    for (int c = 11; c <= 15; c++) run_cycle(1'b1, 1'b0, LABEL_WIDTH'(5));
    check("label_mid", label_out, 2);
    for (int c = 16; c <= 19; c++) run_cycle(1'b1, 1'b0, LABEL_WIDTH'(5));
    check("label_end", label_out, 2);

    // Asynchronous reset while a sample is held.
    check("pre_reset_valid", valid, 1);
    @(negedge clk);
    #2;
    rst = 1'b1;
    #1;
    check_zero("async_reset");
    model_reset();
    enable = 1'b0;
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    measure_first_valid("post_reset_first_valid");

    // Saturation with ready held low, then release.
    apply_reset();
    for (int c = 1; c <= 72; c++) run_cycle(1'b1, 1'b0, LABEL_WIDTH'($urandom));
    check("sat_ovf", ovf, OVF_MAX);
    valid_run = 0;
    for (int c = 73; c <= 78; c++) begin
      run_cycle(1'b1, 1'b1, LABEL_WIDTH'($urandom));
      if (valid === 1'b1) valid_run++;
    end
    check("release_valid_count", valid_run, CAP);
    check("sat_ovf_hold", ovf, OVF_MAX);

    // Randomized enable, ready and tags.
    apply_reset();
    for (int c = 0; c < 600; c++) begin
      run_cycle(($urandom_range(0, 9) != 0), ($urandom_range(0, 4) < 3),
                LABEL_WIDTH'($urandom));
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
